// File: rtl/pic_banked_regfile.sv
// PIC16C5x-style register file with FSR-banked GPRs, OPTION and a prescaled TMR0.
// Define REGFILE_TMR0_EXT_EN to let TMR0 count a synchronized t0cki edge when OPTION.T0CS=1.
module pic_banked_regfile #(
    parameter int DATA_WIDTH  = 8,
    parameter int BANK_BITS   = 2,
    parameter int PC_WIDTH    = 11,
    parameter int PORTA_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             wr_cmd,
    input  logic [4:0]             file_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [DATA_WIDTH-1:0]  status_in,
    input  logic                   cyc_en,
    input  logic                   t0cki,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic [PORTA_WIDTH-1:0] porta_in,
    input  logic [DATA_WIDTH-1:0]  portb_in,
    input  logic [DATA_WIDTH-1:0]  portc_in,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DATA_WIDTH-1:0]  fsr_out,
    output logic [DATA_WIDTH-1:0]  status_out,
    output logic [DATA_WIDTH-1:0]  option_out,
    output logic [PORTA_WIDTH-1:0] porta_out,
    output logic [DATA_WIDTH-1:0]  portb_out,
    output logic [DATA_WIDTH-1:0]  portc_out,
    output logic                   tmr0_ovf
);
    localparam int NUM_BANKS = 2 ** BANK_BITS;
    localparam int GPR_DEPTH = 8 + 16 * NUM_BANKS;
    localparam int GPR_AW    = $clog2(GPR_DEPTH);

    localparam logic [2:0] CMD_STATUS   = 3'b001;
    localparam logic [2:0] CMD_FILE     = 3'b010;
    localparam logic [2:0] CMD_FILE_ST  = 3'b011;
    localparam logic [2:0] CMD_FSR      = 3'b100;
    localparam logic [2:0] CMD_OPTION   = 3'b101;

    logic [DATA_WIDTH-1:0]  gpr [GPR_DEPTH];
    logic [DATA_WIDTH-1:0]  status;
    logic [DATA_WIDTH-1:0]  fsr;
    logic [DATA_WIDTH-1:0]  option;
    logic [DATA_WIDTH-1:0]  tmr0;
    logic [7:0]             presc;
    logic [1:0]             inhibit;

    logic [4:0]             eff_addr;
    logic [BANK_BITS-1:0]   bank;
    logic [GPR_AW-1:0]      gpr_idx;
    logic                   file_we;
    logic                   tmr0_wr;
    logic                   tick;
    logic [7:0]             presc_limit;
    logic                   presc_hit;
    logic                   bump;

    // eff_addr==0 can only arise from INDF through an FSR that also points at INDF
    assign eff_addr = (file_addr == 5'd0) ? fsr[4:0] : file_addr;
    assign bank     = fsr[4+BANK_BITS:5];
    assign gpr_idx  = eff_addr[4] ? (GPR_AW'({bank, eff_addr[3:0]}) + GPR_AW'(8))
                                  : GPR_AW'(eff_addr[2:0]);
    assign file_we  = ((wr_cmd == CMD_FILE) || (wr_cmd == CMD_FILE_ST)) && (eff_addr != 5'd0);
    assign tmr0_wr  = file_we && (eff_addr == 5'd1);

    always_comb begin
        rd_data = '0;
        case (eff_addr)
            5'd0:    rd_data = '0;
            5'd1:    rd_data = tmr0;
            5'd2:    rd_data = pc_in[7:0];
            5'd3:    rd_data = status;
            5'd4:    rd_data = fsr;
            5'd5:    rd_data = DATA_WIDTH'(porta_in);
            5'd6:    rd_data = portb_in;
            5'd7:    rd_data = portc_in;
            default: rd_data = gpr[gpr_idx];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status    <= 8'h18;
            fsr       <= '0;
            option    <= 8'hFF;
            porta_out <= '0;
            portb_out <= '0;
            portc_out <= '0;
            for (int i = 0; i < GPR_DEPTH; i++) gpr[i] <= '0;
        end else begin
            // TO/PD survive a STATUS file write; with 011 they come from the ALU
            if (file_we && (eff_addr == 5'd3))
                status <= {wr_data[7:5],
                           (wr_cmd == CMD_FILE_ST) ? status_in[4:3] : status[4:3],
                           wr_data[2:0]};
            else if ((wr_cmd == CMD_STATUS) || (wr_cmd == CMD_FILE_ST))
                status <= status_in;

            if (wr_cmd == CMD_FSR || (file_we && eff_addr == 5'd4)) fsr <= wr_data;
            if (wr_cmd == CMD_OPTION) option <= wr_data;
            if (file_we && eff_addr == 5'd5) porta_out <= wr_data[PORTA_WIDTH-1:0];
            if (file_we && eff_addr == 5'd6) portb_out <= wr_data;
            if (file_we && eff_addr == 5'd7) portc_out <= wr_data;
            if (file_we && eff_addr >= 5'd8) gpr[gpr_idx] <= wr_data;
        end
    end

`ifdef REGFILE_TMR0_EXT_EN
    logic [2:0] t0_sync;
    logic       ext_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) t0_sync <= '0;
        else      t0_sync <= {t0_sync[1:0], t0cki};
    end

    assign ext_edge = option[4] ? (~t0_sync[1] & t0_sync[2]) : (t0_sync[1] & ~t0_sync[2]);
    assign tick     = option[5] ? ext_edge : cyc_en;
`else
    logic unused_t0cki;
    assign unused_t0cki = t0cki;
    assign tick         = cyc_en;
`endif

    logic unused_pc_hi;
    assign unused_pc_hi = ^pc_in[PC_WIDTH-1:8];

    // divide ratio 2^(PS+1): limit is PS+1 ones
    assign presc_limit = 8'hFF >> (3'd7 - option[2:0]);
    assign presc_hit   = (presc == presc_limit);
    assign bump        = option[3] | presc_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr0     <= '0;
            presc    <= '0;
            inhibit  <= '0;
            tmr0_ovf <= 1'b0;
        end else begin
            tmr0_ovf <= 1'b0;
            if (tmr0_wr) begin
                tmr0    <= wr_data;
                presc   <= '0;
                inhibit <= 2'd2;
            end else if (tick) begin
                if (inhibit != 2'd0) begin
                    inhibit <= inhibit - 2'd1;
                end else begin
                    if (!option[3]) presc <= presc_hit ? 8'd0 : presc + 8'd1;
                    if (bump) begin
                        tmr0     <= tmr0 + 8'd1;
                        tmr0_ovf <= (tmr0 == 8'hFF);
                    end
                end
            end
        end
    end

    assign fsr_out    = fsr;
    assign status_out = status;
    assign option_out = option;
endmodule

// File: tb/tb_pic_banked_regfile.sv
// Bench for pic_banked_regfile: directed literal checks plus random stimulus vs a behavioural model.
module tb_pic_banked_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  wr_cmd;
    logic [4:0]  file_addr;
    logic [7:0]  wr_data, status_in;
    logic        cyc_en, t0cki;
    logic [10:0] pc_in;
    logic [3:0]  porta_in;
    logic [7:0]  portb_in, portc_in;
    logic [7:0]  rd_data, fsr_out, status_out, option_out, portb_out, portc_out;
    logic [3:0]  porta_out;
    logic        tmr0_ovf;

    pic_banked_regfile dut (
        .clk(clk), .rst(rst), .wr_cmd(wr_cmd), .file_addr(file_addr), .wr_data(wr_data),
        .status_in(status_in), .cyc_en(cyc_en), .t0cki(t0cki), .pc_in(pc_in),
        .porta_in(porta_in), .portb_in(portb_in), .portc_in(portc_in), .rd_data(rd_data),
        .fsr_out(fsr_out), .status_out(status_out), .option_out(option_out),
        .porta_out(porta_out), .portb_out(portb_out), .portc_out(portc_out), .tmr0_ovf(tmr0_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_gpr [72];
    logic [7:0] m_status, m_fsr, m_option, m_tmr0, m_portb, m_portc;
    logic [3:0] m_porta;
    int         m_presc, m_inh;
    logic       m_ovf;
    bit         m_hist [3];

    task automatic m_reset();
        for (int i = 0; i < 72; i++) m_gpr[i] = 8'h00;
        m_status = 8'h18; m_fsr = 8'h00; m_option = 8'hFF; m_tmr0 = 8'h00;
        m_porta = 4'h0; m_portb = 8'h00; m_portc = 8'h00;
        m_presc = 0; m_inh = 0; m_ovf = 1'b0;
        for (int i = 0; i < 3; i++) m_hist[i] = 1'b0;
    endtask

    function automatic int m_ea();
        return (file_addr != 5'd0) ? int'(file_addr) : int'(m_fsr[4:0]);
    endfunction

    function automatic int m_gidx(input int a);
        if (a < 16) return a - 8;
        return 8 + int'(m_fsr[6:5]) * 16 + (a - 16);
    endfunction

    function automatic logic [7:0] m_read();
        int a;
        a = m_ea();
        case (a)
            0: return 8'h00;
            1: return m_tmr0;
            2: return pc_in[7:0];
            3: return m_status;
            4: return m_fsr;
            5: return {4'h0, porta_in};
            6: return portb_in;
            7: return portc_in;
            default: return m_gpr[m_gidx(a)];
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reset();
        end else begin : model_step
            int  a, lim;
            bit  we, tk, inc;
            a  = m_ea();
            we = (wr_cmd == 3'd2 || wr_cmd == 3'd3) && (a != 0);
`ifdef REGFILE_TMR0_EXT_EN
            if (m_option[5]) tk = m_option[4] ? (!m_hist[1] && m_hist[2]) : (m_hist[1] && !m_hist[2]);
            else tk = cyc_en;
            m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = t0cki;
`else
            tk = cyc_en;
`endif
            m_ovf = 1'b0;
            if (we && a == 1) begin
                m_tmr0 = wr_data; m_presc = 0; m_inh = 2;
            end else if (tk) begin
                if (m_inh > 0) m_inh--;
                else begin
                    if (m_option[3]) inc = 1'b1;
                    else begin
                        lim     = (1 << (int'(m_option[2:0]) + 1)) - 1;
                        inc     = (m_presc == lim);
                        m_presc = inc ? 0 : (m_presc + 1) % 256;
                    end
                    if (inc) begin
                        m_ovf  = (m_tmr0 == 8'hFF);
                        m_tmr0 = m_tmr0 + 8'd1;
                    end
                end
            end
            if (we && a == 3)
                m_status = {wr_data[7:5], (wr_cmd == 3'd3) ? status_in[4:3] : m_status[4:3], wr_data[2:0]};
            else if (wr_cmd == 3'd1 || wr_cmd == 3'd3)
                m_status = status_in;
            if (we) begin
                if (a == 4) m_fsr = wr_data;
                else if (a == 5) m_porta = wr_data[3:0];
                else if (a == 6) m_portb = wr_data;
                else if (a == 7) m_portc = wr_data;
                else if (a >= 8) m_gpr[m_gidx(a)] = wr_data;
            end
            if (wr_cmd == 3'd4) m_fsr = wr_data;
            if (wr_cmd == 3'd5) m_option = wr_data;
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("rd_data", rd_data, m_read());
            chk("fsr_out", fsr_out, m_fsr);
            chk("status_out", status_out, m_status);
            chk("option_out", option_out, m_option);
            chk("porta_out", porta_out, m_porta);
            chk("portb_out", portb_out, m_portb);
            chk("portc_out", portc_out, m_portc);
            chk("tmr0_ovf", tmr0_ovf, m_ovf);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_cmd(input logic [2:0] cmd, input logic [4:0] addr, input logic [7:0] data);
        @(negedge clk);
        wr_cmd = cmd; file_addr = addr; wr_data = data;
        @(negedge clk);
        wr_cmd = 3'd0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] addr, input logic [7:0] exp);
        file_addr = addr;
        #1;
        chk(name, rd_data, exp);
    endtask

    logic [7:0] exp_rst [32];

    initial begin
        wr_cmd = 3'd0; file_addr = 5'd0; wr_data = 8'h00; status_in = 8'h00;
        cyc_en = 1'b0; t0cki = 1'b0; pc_in = 11'h5A3;
        porta_in = 4'hC; portb_in = 8'h77; portc_in = 8'h81;
        rst = 1'b1;
        m_reset();
        #2 rst = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 32; i++) exp_rst[i] = 8'h00;
        exp_rst[2] = 8'hA3; exp_rst[3] = 8'h18; exp_rst[5] = 8'h0C;
        exp_rst[6] = 8'h77; exp_rst[7] = 8'h81;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rd_chk("reset_read", 5'(i), exp_rst[i]);
        end
        chk("reset_option", option_out, 8'hFF);
        chk("reset_status", status_out, 8'h18);

        // banking
        do_cmd(3'd4, 5'd0, 8'h20);
        do_cmd(3'd2, 5'h10, 8'h5A);
        do_cmd(3'd4, 5'd0, 8'h00);
        rd_chk("bank0_read", 5'h10, 8'h00);
        do_cmd(3'd4, 5'd0, 8'h20);
        rd_chk("bank1_read", 5'h10, 8'h5A);
        do_cmd(3'd4, 5'd0, 8'h60);
        do_cmd(3'd2, 5'h08, 8'hA5);
        do_cmd(3'd4, 5'd0, 8'h00);
        rd_chk("shared_read", 5'h08, 8'hA5);

        // indirect
        do_cmd(3'd4, 5'd0, 8'h13);
        do_cmd(3'd2, 5'h00, 8'h3C);
        do_cmd(3'd4, 5'd0, 8'h00);
        rd_chk("indirect_write", 5'h13, 8'h3C);
        do_cmd(3'd2, 5'h00, 8'h77);
        rd_chk("indf_indf_read", 5'h00, 8'h00);
        rd_chk("indf_indf_nowrite", 5'h13, 8'h3C);
        chk("indf_indf_status", status_out, 8'h18);

        // STATUS priority
        status_in = 8'h00;
        do_cmd(3'd3, 5'h03, 8'hFF);
        chk("status_011", status_out, 8'hE7);
        status_in = 8'h18;
        do_cmd(3'd1, 5'h00, 8'h00);
        chk("status_001", status_out, 8'h18);

        // TMR0 with prescaler 1:8
        do_cmd(3'd5, 5'h00, 8'h02);
        do_cmd(3'd2, 5'h01, 8'hFE);
        cyc_en = 1'b1;
        rd_chk("tmr0_load", 5'h01, 8'hFE);
        repeat (9) @(negedge clk);
        rd_chk("tmr0_hold9", 5'h01, 8'hFE);
        @(negedge clk);
        rd_chk("tmr0_inc10", 5'h01, 8'hFF);
        repeat (7) @(negedge clk);
        chk("ovf_before", tmr0_ovf, 1'b0);
        @(negedge clk);
        rd_chk("tmr0_wrap", 5'h01, 8'h00);
        chk("ovf_pulse", tmr0_ovf, 1'b1);
        @(negedge clk);
        chk("ovf_single", tmr0_ovf, 1'b0);
        repeat (2) @(negedge clk);
        wr_cmd = 3'd2; file_addr = 5'h01; wr_data = 8'h40;
        @(negedge clk);
        wr_cmd = 3'd0;
        rd_chk("tmr0_midwrite", 5'h01, 8'h40);
        repeat (9) @(negedge clk);
        rd_chk("tmr0_inhibit_hold", 5'h01, 8'h40);
        @(negedge clk);
        rd_chk("tmr0_inhibit_inc", 5'h01, 8'h41);
        cyc_en = 1'b0;

`ifdef REGFILE_TMR0_EXT_EN
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        cyc_en = 1'b1;
        do_cmd(3'd5, 5'h01, 8'h28);
        @(negedge clk);
        t0cki = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd_chk("ext_latency0", 5'h01, 8'h00);
        @(negedge clk);
        rd_chk("ext_latency1", 5'h01, 8'h01);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) t0cki = 1'b0;
            @(negedge clk);
            @(negedge clk) t0cki = 1'b1;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        rd_chk("ext_count", 5'h01, 8'h05);
        cyc_en = 1'b0;
`endif

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst       = 1'b1;
            wr_cmd    = 3'($urandom_range(0, 5));
            file_addr = ($urandom_range(0, 3) == 0) ? 5'd1 : 5'($urandom);
            wr_data   = 8'($urandom);
            status_in = 8'($urandom);
            cyc_en    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) t0cki = ~t0cki;
            pc_in     = 11'($urandom);
            porta_in  = 4'($urandom);
            portb_in  = 8'($urandom);
            portc_in  = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #3 rst = 1'b0;
                #1 chk("async_reset_status", status_out, 8'h18);
                chk("async_reset_option", option_out, 8'hFF);
            end
        end

        @(negedge clk);
        rst = 1'b1; wr_cmd = 3'd0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pic_banked_regfile.md
Name: pic_banked_regfile

Overview:
Next-generation PIC16C5x special-function and general-purpose register file.
- Adds FSR-based GPR banking for PIC16C57-class memory sizes.
- Adds a working TMR0 with an OPTION register and a prescaler.
- Sits between the decode/ALU stage and the I/O pins; serves direct and INDF/FSR-indirect accesses.

Parameters:
- DATA_WIDTH, 8, register width; the block is specified for 8 only.
- BANK_BITS, 2, FSR bits [4+BANK_BITS:5] select the bank; 2**BANK_BITS banks.
- PC_WIDTH, 11, width of pc_in; PCL reads pc_in[7:0].
- PORTA_WIDTH, 4, PORTA width; reads zero-extend to 8 bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- wr_cmd  in  3  000 none, 001 status load, 010 file write, 011 file write + status load, 100 FSR load, 101 OPTION load
- file_addr  in  5  direct file address
- wr_data  in  8  write data
- status_in  in  8  ALU status
- cyc_en  in  1  instruction-cycle strobe: TMR0 internal tick
- t0cki  in  1  external TMR0 clock pin (used only with the optional feature)
- pc_in  in  PC_WIDTH  program counter
- porta_in / portb_in / portc_in  in  PORTA_WIDTH/8/8  pin inputs
- rd_data  out  8  combinational read of file_addr
- fsr_out / status_out / option_out  out  8  register contents
- porta_out / portb_out / portc_out  out  PORTA_WIDTH/8/8  output latches
- tmr0_ovf  out  1  one-cycle pulse when TMR0 wraps FF->00

Behaviour:
- Effective address:
  - Direct: file_addr.
  - Indirect (file_addr==0): FSR[4:0].
  - Bank = FSR[4+BANK_BITS:5] in both cases.
- Map per bank:
  - 00 INDF, 01 TMR0, 02 PCL, 03 STATUS, 04 FSR, 05-07 PORTA/B/C.
  - 08-0F: GPR shared by all banks (8 bytes).
  - 10-1F: banked GPR, 16 bytes per bank.
  - Total GPR = 8 + 16*2**BANK_BITS.
- Reads:
  - Combinational. Ports return pin inputs, not latches.
  - INDF-via-INDF returns 00. No X on any address.
- Writes: take effect at posedge.
  - INDF-via-INDF and PCL writes are discarded.
  - A STATUS write keeps bits [4:3] (TO/PD) and takes the other bits from wr_data.
- Priority with wr_cmd 011 when the target is STATUS: wr_data wins for [7:5],[2:0]; status_in supplies [4:3]. Other targets: status <= status_in.
- wr_cmd 100 loads FSR; 101 loads OPTION. Both are independent of file_addr.
- Reset values:
  - STATUS 8'h18, FSR 00, OPTION FF, TMR0 00, prescaler 00, tmr0_ovf 0.
  - Port latches 0; all GPR 00.
- TMR0 tick source: cyc_en.
- OPTION[3] (PSA):
  - PSA=1: TMR0 +1 on every tick.
  - PSA=0: 8-bit prescaler +1 on every tick. TMR0 +1 on the tick where prescaler == 2**(OPTION[2:0]+1)-1; the prescaler then returns to 0.
- TMR0 write (direct or indirect):
  - Loads wr_data and clears the prescaler.
  - Inhibits increment for the next 2 ticks.
  - A write wins over a same-cycle increment.
- tmr0_ovf: asserted the cycle after TMR0 goes FF->00 by increment; never asserted by a write.
- Reset mid-count: all state returns to reset values immediately (asynchronous).

Optional Feature:
- REGFILE_TMR0_EXT_EN defined:
  - When OPTION[5] (T0CS) = 1, the tick comes from t0cki via a 2-flop synchronizer plus an edge detect; cyc_en is ignored.
  - OPTION[4] (T0SE): 0 = rising edge, 1 = falling edge.
  - Note: with OPTION at its reset value FF, TMR0 starts on the external falling-edge source.
- Undefined:
  - t0cki is unused; T0CS/T0SE bits are storage only.
  - The tick is always cyc_en.

Test Plan:
- Reset, then read all 32 addresses with FSR=00 -> STATUS 18, OPTION FF, GPR 00, PCL = pc_in[7:0], INDF 00.
- Bank: FSR=20, write 5A to 0x10; FSR=00, read 0x10 -> 00; FSR=20 -> 5A; write A5 to 0x08 with FSR=60; read 0x08 with FSR=00 -> A5.
- Indirect: FSR=13, wr_cmd 010 to addr 00 with 3C -> GPR 13 = 3C; FSR=00, wr to INDF -> nothing changes.
- STATUS: wr_cmd 011, addr 03, wr_data FF, status_in 00 -> STATUS E7; wr_cmd 001 with 18 -> 18.
- TMR0: OPTION 02 (PSA=0, PS=2, T0CS=0), cyc_en held high, TMR0=FE -> +1 every 8 ticks; FF->00 produces one tmr0_ovf pulse; a write mid-count -> no increment for 2 ticks, prescaler 0.
- With REGFILE_TMR0_EXT_EN: OPTION 28 (T0CS=1, PSA=1), 5 rising t0cki edges -> TMR0=05, with 2-cycle sync latency; cyc_en ignored.
